// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, NOP encoding and fetch FSM state encodings for the IF stage.
package if_fetch_stage_pkg;

  localparam int          IF_XLEN    = 32;
  localparam int          IF_INSTR_W = 32;
  localparam logic [31:0] IF_NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_BUF  = 2'd2,
    IF_DROP = 2'd3
  } if_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory req/ack bus; the fetch stage is the master.
interface if_fetch_stage_if #(
  parameter int XLEN        = 32,
  parameter int INSTR_WIDTH = 32
) ();

  logic                   imem_req;
  logic [XLEN-1:0]        imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load enable; bubble insertion overrides load.
module if_fetch_stage_if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter int XLEN        = IF_XLEN,
  parameter int INSTR_WIDTH = IF_INSTR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_bubble,
  input  logic [XLEN-1:0]        i_pc,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  output logic [XLEN-1:0]        o_pc,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic                   o_valid
);

  logic [XLEN-1:0]        r_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_valid;

  // A bubble keeps the stale PC; only instr/valid are meaningful downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= '0;
      r_instr <= INSTR_WIDTH'(IF_NOP);
      r_valid <= 1'b0;
    end else if (i_bubble) begin
      r_instr <= INSTR_WIDTH'(IF_NOP);
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with req/ack memory handshake and IF/ID register.
// Optional IF_PERF_CNT_EN adds saturating stall-cycle and flush counters.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int               XLEN        = IF_XLEN,
  parameter int               INSTR_WIDTH = IF_INSTR_W,
  parameter logic [XLEN-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pcwrite,
  input  logic                   ifidwrite,
  input  logic                   flush,
  input  logic [XLEN-1:0]        redirect_pc,
  if_fetch_stage_if.master       imem,
  output logic [XLEN-1:0]        pc_id,
  output logic [INSTR_WIDTH-1:0] instr_id,
  output logic                   valid_id
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_stall_cycles,
  output logic [31:0]            flush_count
`endif
);

  if_state_e              r_state, w_next_state;
  logic [XLEN-1:0]        r_pc, r_pending, w_pc_next;
  logic [INSTR_WIDTH-1:0] r_buf, w_ifid_instr;
  logic w_advance, w_pc_load, w_pend_load, w_buf_load, w_ifid_load, w_ifid_bubble;

  assign w_advance = pcwrite & ifidwrite;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IF_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_pc_load     = 1'b0;
    w_pc_next     = r_pc;
    w_pend_load   = 1'b0;
    w_buf_load    = 1'b0;
    w_ifid_load   = 1'b0;
    w_ifid_bubble = 1'b0;
    w_ifid_instr  = imem.imem_rdata;
    case (r_state)
      IF_IDLE: w_next_state = IF_REQ;
      IF_REQ: begin
        if (imem.imem_ack) begin
          if (flush) begin
            w_pc_load     = 1'b1;
            w_pc_next     = redirect_pc;
            w_ifid_bubble = 1'b1;
          end else if (w_advance) begin
            w_ifid_load = 1'b1;
            w_pc_load   = 1'b1;
            w_pc_next   = r_pc + XLEN'(4);
          end else begin
            w_buf_load   = 1'b1;
            w_next_state = IF_BUF;
          end
        end else if (flush) begin
          // Request cannot be retracted: park the target until the ack drains it.
          w_pend_load   = 1'b1;
          w_ifid_bubble = 1'b1;
          w_next_state  = IF_DROP;
        end else if (ifidwrite) begin
          w_ifid_bubble = 1'b1;
        end
      end
      IF_BUF: begin
        if (flush) begin
          w_pc_load     = 1'b1;
          w_pc_next     = redirect_pc;
          w_ifid_bubble = 1'b1;
          w_next_state  = IF_REQ;
        end else if (w_advance) begin
          w_ifid_load  = 1'b1;
          w_ifid_instr = r_buf;
          w_pc_load    = 1'b1;
          w_pc_next    = r_pc + XLEN'(4);
          w_next_state = IF_REQ;
        end
      end
      IF_DROP: begin
        w_ifid_bubble = flush | ifidwrite;
        w_pend_load   = flush;
        if (imem.imem_ack) begin
          w_pc_load    = 1'b1;
          w_pc_next    = flush ? redirect_pc : r_pending;
          w_next_state = IF_REQ;
        end
      end
      default: w_next_state = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_pending <= RESET_PC;
      r_buf     <= INSTR_WIDTH'(IF_NOP);
    end else begin
      if (w_pc_load)   r_pc      <= w_pc_next;
      if (w_pend_load) r_pending <= redirect_pc;
      if (w_buf_load)  r_buf     <= imem.imem_rdata;
    end
  end

  // In DROP the PC still names the outstanding request, so it drives the bus.
  assign imem.imem_req  = (r_state == IF_REQ) || (r_state == IF_DROP);
  assign imem.imem_addr = r_pc;

  if_fetch_stage_if_id_reg #(
    .XLEN        (XLEN),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_ifid_load),
    .i_bubble (w_ifid_bubble),
    .i_pc     (r_pc),
    .i_instr  (w_ifid_instr),
    .o_pc     (pc_id),
    .o_instr  (instr_id),
    .o_valid  (valid_id)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (imem.imem_req && !imem.imem_ack) r_stall_cnt <= sat_inc32(r_stall_cnt);
      if (flush)                           r_flush_cnt <= sat_inc32(r_flush_cnt);
    end
  end

  assign fetch_stall_cycles = r_stall_cnt;
  assign flush_count        = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a scoreboard of expected IF/ID contents.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcwrite, ifidwrite, flush;
  logic [31:0] redirect_pc;
  logic [31:0] pc_id, instr_id;
  logic        valid_id;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] last_pc, last_instr;

  always #5 clk = ~clk;

  if_fetch_stage_if #(.XLEN(32), .INSTR_WIDTH(32)) imem ();

  if_fetch_stage #(
    .XLEN        (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pcwrite     (pcwrite),
    .ifidwrite   (ifidwrite),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .pc_id       (pc_id),
    .instr_id    (instr_id),
    .valid_id    (valid_id)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_pc"}, pc_id, e.pc);
      check({tag, "_instr"}, instr_id, e.instr);
      check({tag, "_valid"}, 32'(valid_id), 32'd1);
      last_pc    = e.pc;
      last_instr = e.instr;
      $display("ifid pc=%h instr=%h valid=%0b", pc_id, instr_id, valid_id);
    end
  endtask

  // One zero-wait fetch that is allowed to advance into IF/ID.
  task automatic fetch_ok(input logic [31:0] a);
    check("fetch_req", 32'(imem.imem_req), 32'd1);
    check("fetch_addr", imem.imem_addr, a);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = mem_word(a);
    exp_q.push_back('{pc: a, instr: mem_word(a)});
    step();
    imem.imem_ack = 1'b0;
    pop_check("fetch");
  endtask

  initial begin
    rst = 1'b0; pcwrite = 1'b1; ifidwrite = 1'b1; flush = 1'b0; redirect_pc = '0;
    imem.imem_ack = 1'b0; imem.imem_rdata = '0;
    #12;
    check("rst_req", 32'(imem.imem_req), 32'd0);
    check("rst_addr", imem.imem_addr, 32'h0);
    check("rst_pc_id", pc_id, 32'h0);
    check("rst_instr", instr_id, IF_NOP);
    check("rst_valid", 32'(valid_id), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("first_req", 32'(imem.imem_req), 32'd1);

    for (int k = 0; k < 4; k++) fetch_ok(32'(4 * k));

    // Two-cycle stall while the ack for 0x10 arrives
    check("stall_addr", imem.imem_addr, 32'h10);
    pcwrite = 1'b0; ifidwrite = 1'b0;
    imem.imem_ack = 1'b1; imem.imem_rdata = mem_word(32'h10);
    exp_q.push_back('{pc: 32'h10, instr: mem_word(32'h10)});
    step();
    imem.imem_ack = 1'b0;
    for (int s = 0; s < 2; s++) begin
      check("buf_req", 32'(imem.imem_req), 32'd0);
      check("buf_hold_pc", pc_id, last_pc);
      check("buf_hold_instr", instr_id, last_instr);
      check("buf_hold_valid", 32'(valid_id), 32'd1);
      if (s == 0) step();
    end
    pcwrite = 1'b1; ifidwrite = 1'b1;
    step();
    pop_check("buf_release");
    check("after_buf_addr", imem.imem_addr, 32'h14);
    fetch_ok(32'h14); fetch_ok(32'h18); fetch_ok(32'h1C);

    // Flush coinciding with ack at 0x20
    check("flack_addr", imem.imem_addr, 32'h20);
    imem.imem_ack = 1'b1; imem.imem_rdata = mem_word(32'h20);
    flush = 1'b1; redirect_pc = 32'h200;
    step();
    imem.imem_ack = 1'b0; flush = 1'b0;
    check("flack_valid", 32'(valid_id), 32'd0);
    check("flack_instr", instr_id, IF_NOP);
    check("flack_addr_new", imem.imem_addr, 32'h200);
    check("flack_req", 32'(imem.imem_req), 32'd1);
    $display("flush+ack redirect addr=%h valid=%0b", imem.imem_addr, valid_id);

    imem.imem_ack = 1'b1; flush = 1'b1; redirect_pc = 32'h30;
    step();
    imem.imem_ack = 1'b0; flush = 1'b0;
    check("to30_addr", imem.imem_addr, 32'h30);

    // Flush with the 0x30 request still outstanding, then a second flush
    flush = 1'b1; redirect_pc = 32'h200;
    step();
    flush = 1'b0;
    check("drop_addr0", imem.imem_addr, 32'h30);
    check("drop_req0", 32'(imem.imem_req), 32'd1);
    check("drop_valid0", 32'(valid_id), 32'd0);
    step();
    check("drop_addr1", imem.imem_addr, 32'h30);
    flush = 1'b1; redirect_pc = 32'h300;
    step();
    flush = 1'b0;
    check("drop_addr2", imem.imem_addr, 32'h30);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hBAD0_BAD0;
    step();
    imem.imem_ack = 1'b0;
    check("drop_target", imem.imem_addr, 32'h300);
    check("drop_req_after", 32'(imem.imem_req), 32'd1);
    check("drop_valid_after", 32'(valid_id), 32'd0);
    $display("drop done addr=%h", imem.imem_addr);

    // Two-cycle wait memory: bubbles between fetches, PC sequence gap-free
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 2; w++) begin
        step();
        check("wait_valid", 32'(valid_id), 32'd0);
        check("wait_instr", instr_id, IF_NOP);
        check("wait_addr", imem.imem_addr, 32'h300 + 32'(4 * k));
      end
      fetch_ok(32'h300 + 32'(4 * k));
    end

    // PC wrap at the top of the address space
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hBAD1_BAD1;
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    imem.imem_ack = 1'b0; flush = 1'b0;
    check("wrap_addr_top", imem.imem_addr, 32'hFFFF_FFFC);
    fetch_ok(32'hFFFF_FFFC);
    check("wrap_addr_zero", imem.imem_addr, 32'h0);

    // Asynchronous reset in the middle of a wait
    step();
    check("midwait_req", 32'(imem.imem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_req", 32'(imem.imem_req), 32'd0);
    check("async_rst_valid", 32'(valid_id), 32'd0);
    check("async_rst_instr", instr_id, IF_NOP);
    check("async_rst_addr", imem.imem_addr, 32'h0);
    $display("async reset req=%0b valid=%0b", imem.imem_req, valid_id);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the ID-stage hazard detection unit.
- Holds the PC and issues requests over a req/ack instruction-memory handshake.
- Honours the PC-write and IF/ID-write stall enables from hazard detection, and the taken-branch/jump flush from EX.
- Presents {pc, instruction, valid} to ID.

Parameters:
XLEN, 32, address/PC width
INSTR_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
pcwrite  input  1  PC may advance (0 = load-use stall)
ifidwrite  input  1  IF/ID register may load (0 = stall)
flush  input  1  taken branch/jump resolved in EX; redirect fetch
redirect_pc  input  XLEN  target PC, valid when flush=1
imem_req  output  1  fetch request
imem_addr  output  XLEN  fetch address; stable while imem_req=1 and no ack
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  INSTR_WIDTH  fetched instruction
pc_id  output  XLEN  PC of instruction in IF/ID
instr_id  output  INSTR_WIDTH  instruction in IF/ID
valid_id  output  1  IF/ID holds a real instruction

Behaviour:
- advance = pcwrite & ifidwrite. Flush has priority over stall and over everything else.
- Reset values (async, while rst=0):
  - state=IDLE, imem_req=0, imem_addr=RESET_PC
  - pc_id=0, instr_id=NOP (32'h0000_0013), valid_id=0
  - buffer empty
- FSM states: IDLE, REQ, BUF, DROP.
- IDLE: imem_req=0. Goes to REQ on the next cycle unconditionally, so the first request is asserted on the first edge after reset release.
- REQ: imem_req=1, imem_addr=pc.
  - ack & flush: discard rdata; pc<=redirect_pc; IF/ID<=bubble (valid 0, NOP); stay REQ.
  - ack & advance: IF/ID<={pc, rdata, 1}; pc<=pc+4 (wraps modulo 2^XLEN); stay REQ (back-to-back, 1 instr/cycle at zero-wait memory).
  - ack & !advance: rdata->buffer; imem_req<=0; IF/ID held; go BUF.
  - !ack & flush: keep the outstanding address on imem_addr; redirect_pc->pending register; IF/ID<=bubble; go DROP.
  - !ack & ifidwrite & !flush: IF/ID<=bubble (valid 0). pc unchanged.
  - !ack & !ifidwrite: IF/ID held.
- BUF: imem_req=0.
  - flush: drop buffer; pc<=redirect_pc; IF/ID<=bubble; go REQ.
  - advance: IF/ID<={pc, buffer, 1}; pc<=pc+4; go REQ.
  - Otherwise hold.
- DROP: imem_req=1 at the old address until ack.
  - On ack: discard rdata; pc<=pending; go REQ.
  - A further flush in DROP overwrites pending (last flush wins).
  - IF/ID<=bubble whenever ifidwrite=1.
- The outstanding request is never retracted or changed before its ack.
- Latency: fetch-to-ID is 1 cycle after ack at zero wait. Redirect-to-first-fetch-of-target: 1 cycle (REQ/BUF) or ack+1 (DROP).
- Simultaneous pcwrite != ifidwrite is treated as a stall (advance=0).
- Reset asserted mid-transaction: immediate return to reset values. Memory must tolerate an abandoned request.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs fetch_stall_cycles[31:0] (cycles in REQ/DROP with imem_req=1 & !imem_ack) and flush_count[31:0] (cycles with flush=1). Both reset to 0, saturating at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
Shared package/defines (riscv_def): XLEN, INSTR_WIDTH, NOP encoding 32'h0000_0013, FSM state encodings (IF_IDLE, IF_REQ, IF_BUF, IF_DROP).
One natural sub-module: if_id_reg (IF/ID register with load enable and bubble-insert), instantiated once.

Test Plan:
- Reset release, RESET_PC=0, zero-wait ack, no stalls -> imem_addr 0,4,8,...; pc_id/instr_id follow one cycle after each ack, valid_id=1 continuously.
- Stall (pcwrite=ifidwrite=0) for 2 cycles while ack arrives for pc=0x10 -> state BUF, imem_req=0, IF/ID held. On release, IF/ID={0x10, buffered instr, 1}; next request at 0x14.
- flush=1, redirect_pc=0x200, with ack same cycle at pc=0x20 -> rdata dropped, valid_id=0 next cycle, next imem_addr=0x200.
- flush while request to 0x30 is pending (ack 3 cycles later) -> imem_addr stays 0x30 until ack, data discarded, then imem_addr=0x200. Second flush to 0x300 during DROP -> target 0x300.
- Memory with 2-cycle wait, ifidwrite=1 -> bubbles (valid_id=0, instr_id=NOP) inserted in non-ack cycles; PC sequence gap-free.
- pc=32'hFFFF_FFFC fetch, advance -> next imem_addr=0; rst pulled low mid-wait -> imem_req=0, valid_id=0 immediately (asynchronous).
